// File: rtl/uart_baud_if.sv
// Control/tick bundle between the baud generator and the UART rx/tx FSMs.
// The master drives the divisor and control pulses; the slave returns the tick enables.
interface uart_baud_if #(
  parameter int DIV_WIDTH  = 16,
  parameter int FRAC_WIDTH = 4
);
  logic                  i_enable;
  logic                  i_load;
  logic                  i_sync;
  logic [DIV_WIDTH-1:0]  i_div_int;
  logic [FRAC_WIDTH-1:0] i_div_frac;
  logic                  o_tick;
  logic                  o_mid_tick;
  logic                  o_bit_tick;
  logic                  o_cfg_err;

  modport master (
    output i_enable, i_load, i_sync, i_div_int, i_div_frac,
    input  o_tick, o_mid_tick, o_bit_tick, o_cfg_err
  );

  modport slave (
    input  i_enable, i_load, i_sync, i_div_int, i_div_frac,
    output o_tick, o_mid_tick, o_bit_tick, o_cfg_err
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional baud-rate generator: oversample, mid-bit and bit ticks from one clock.
// Each period is d or d+1 clocks, with the extra clock inserted by a first-order accumulator.
module uart_baud_gen #(
  parameter int DIV_WIDTH    = 16,
  parameter int FRAC_WIDTH   = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int DEFAULT_DIV  = 651,
  parameter int DEFAULT_FRAC = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  uart_baud_if.slave bif
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_WIDTH-1:0]  div_q, div_d, cnt_q, cnt_d;
  logic [FRAC_WIDTH-1:0] frac_q, frac_d, acc_q, acc_d;
  logic                  carry_q, carry_d;
  logic [OS_W-1:0]       os_q, os_d;

  logic [DIV_WIDTH:0]    d_eff, period_m1;
  logic [FRAC_WIDTH:0]   acc_sum;
  logic                  cfg_err, last, tick;

  // One extra bit so div=2^DIV_WIDTH-1 plus a carry clock cannot overflow.
  assign cfg_err   = (div_q < DIV_WIDTH'(2));
  assign d_eff     = cfg_err ? (DIV_WIDTH+1)'(2) : {1'b0, div_q};
  assign period_m1 = d_eff + {{DIV_WIDTH{1'b0}}, carry_q} - (DIV_WIDTH+1)'(1);
  assign last      = ({1'b0, cnt_q} == period_m1);
  assign acc_sum   = {1'b0, acc_q} + {1'b0, frac_q};

  assign tick           = bif.i_enable & last & ~bif.i_load & ~bif.i_sync;
  assign bif.o_tick     = tick;
  assign bif.o_mid_tick = tick & (os_q == OS_MID);
  assign bif.o_bit_tick = tick & (os_q == OS_LAST);
  assign bif.o_cfg_err  = cfg_err;

  always_comb begin
    div_d   = div_q;
    frac_d  = frac_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    os_d    = os_q;
    if (bif.i_load || bif.i_sync) begin
      if (bif.i_load) begin
        div_d  = bif.i_div_int;
        frac_d = bif.i_div_frac;
      end
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
      os_d    = '0;
    end else if (bif.i_enable) begin
      if (last) begin
        cnt_d            = '0;
        {carry_d, acc_d} = acc_sum;
        os_d             = (os_q == OS_LAST) ? '0 : os_q + OS_W'(1);
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      div_q   <= DIV_WIDTH'(DEFAULT_DIV);
      frac_q  <= FRAC_WIDTH'(DEFAULT_FRAC);
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      os_q    <= '0;
    end else begin
      div_q   <= div_d;
      frac_q  <= frac_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      os_q    <= os_d;
    end
  end
endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench: a tick-time model predicts when each oversample tick lands;
// a negedge monitor pops and compares whenever the generator presents a tick.
module tb_uart_baud_gen;
  localparam int DW = 16;
  localparam int FW = 4;
  localparam int OS = 16;

  logic gclk = 1'b0;
  logic grst_n;
  always #5 gclk = ~gclk;

  uart_baud_if #(.DIV_WIDTH(DW), .FRAC_WIDTH(FW)) bif ();

  uart_baud_gen #(
    .DIV_WIDTH(DW), .FRAC_WIDTH(FW), .OVERSAMPLE(OS),
    .DEFAULT_DIV(651), .DEFAULT_FRAC(1)
  ) dut (
    .i_clk  (gclk),
    .i_reset(grst_n),
    .bif    (bif)
  );

  typedef struct {
    int cyc;
    bit mid;
    bit bt;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;
  bit   exp_cfg = 1'b0;
  bit   exp_tick;

  // Model: after a restart, tick k (0-based) lands on the enabled cycle
  // (k+1)*d + floor(k*frac/2^FW), d = max(div,2).
  int     m_div, m_frac, m_k, m_n;

  function automatic longint tick_at(input int k, input int dv, input int fr);
    longint d;
    d = (dv < 2) ? 2 : dv;
    return (longint'(k) + 1) * d + (longint'(k) * fr) / (1 << FW);
  endfunction

  task automatic model_reset();
    m_div  = 651;
    m_frac = 1;
    m_k    = 0;
    m_n    = 0;
  endtask

  task automatic step(input bit en, input bit ld, input bit sy, input int dv, input int fr);
    exp_t e;
    @(posedge gclk);
    #1;
    cyc++;
    bif.i_enable   = en;
    bif.i_load     = ld;
    bif.i_sync     = sy;
    bif.i_div_int  = DW'(dv);
    bif.i_div_frac = FW'(fr);
    exp_cfg  = (m_div < 2);
    exp_tick = 1'b0;
    if (ld || sy) begin
      if (ld) begin
        m_div  = dv;
        m_frac = fr;
      end
      m_k = 0;
      m_n = 0;
    end else if (en) begin
      m_n++;
      if (longint'(m_n) == tick_at(m_k, m_div, m_frac)) begin
        e.cyc = cyc;
        e.mid = ((m_k % OS) == OS / 2 - 1);
        e.bt  = ((m_k % OS) == OS - 1);
        sbq.push_back(e);
        exp_tick = 1'b1;
        m_k++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge gclk) begin
    exp_t e;
    if (mon_en) begin
      chk("cfg_err", bif.o_cfg_err, exp_cfg);
      if (bif.o_tick === 1'b1) begin
        tests++;
        if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
          fails++;
          $display("FAIL spurious_tick: tick at cyc %0d, next expected %0d", cyc,
                   (sbq.size() == 0) ? -1 : sbq[0].cyc);
        end else begin
          e = sbq.pop_front();
          chk("mid_tick", bif.o_mid_tick, e.mid);
          chk("bit_tick", bif.o_bit_tick, e.bt);
        end
      end else begin
        if (bif.o_mid_tick !== 1'b0 || bif.o_bit_tick !== 1'b0) begin
          tests++;
          fails++;
          $display("FAIL stray_mid_bit: mid %b bit %b without tick at cyc %0d",
                   bif.o_mid_tick, bif.o_bit_tick, cyc);
        end
        if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
          tests++;
          fails++;
          $display("FAIL missing_tick: none at cyc %0d, expected at %0d", cyc, sbq[0].cyc);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    int guard;
    bit en, ld, sy;
    bif.i_enable   = 1'b0;
    bif.i_load     = 1'b0;
    bif.i_sync     = 1'b0;
    bif.i_div_int  = '0;
    bif.i_div_frac = '0;
    grst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge gclk);
    #1;
    chk("rst_tick", bif.o_tick, 1'b0);
    chk("rst_mid", bif.o_mid_tick, 1'b0);
    chk("rst_bit", bif.o_bit_tick, 1'b0);
    chk("rst_cfg_err", bif.o_cfg_err, 1'b0);
    grst_n = 1'b1;
    exp_cfg = 1'b0;
    mon_en = 1'b1;

    step(1'b1, 1'b1, 1'b0, 4, 0);  run(70);        // integer divide, mid/bit on 8th/16th
    step(1'b1, 1'b1, 1'b0, 4, 8);  run(80);        // alternating 4/5 periods
    step(1'b1, 1'b1, 1'b0, 10, 0); run(57);        // realign mid-period
    step(1'b1, 1'b0, 1'b1, 0, 0);  run(170);
    step(1'b1, 1'b1, 1'b0, 8, 0);  run(3);         // pause mid-period
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    run(30);
    step(1'b1, 1'b1, 1'b0, 1, 3);  run(20);        // clamped divisor
    step(1'b1, 1'b1, 1'b0, 0, 0);  run(10);
    step(1'b1, 1'b1, 1'b0, 2, 15); run(40);

    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 99) == 0);
      sy = ($urandom_range(0, 49) == 0);
      step(en, ld, sy, $urandom_range(0, 9), $urandom_range(0, 15));
    end

    // async reset landing in a tick cycle clears the outputs without an edge
    step(1'b1, 1'b1, 1'b0, 5, 3);
    guard = 0;
    do begin
      step(1'b1, 1'b0, 1'b0, 0, 0);
      guard++;
    end while (!exp_tick && guard < 50);
    tests++;
    if (!exp_tick) begin
      fails++;
      $display("FAIL reset_setup: no tick predicted within %0d cycles", guard);
    end
    mon_en = 1'b0;
    void'(sbq.pop_back());
    #2;
    grst_n = 1'b0;
    bif.i_enable = 1'b0;
    #1;
    chk("async_rst_tick", bif.o_tick, 1'b0);
    chk("async_rst_mid", bif.o_mid_tick, 1'b0);
    chk("async_rst_bit", bif.o_bit_tick, 1'b0);
    chk("async_rst_cfg", bif.o_cfg_err, 1'b0);
    repeat (2) @(posedge gclk);
    #1;
    grst_n = 1'b1;
    model_reset();
    exp_cfg = 1'b0;
    mon_en = 1'b1;
    run(1320);                                     // default divisor ticks at 651 and 1302

    @(negedge gclk);
    #1;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expected ticks never seen, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
